// File: rtl/data_mem_bank_if.sv
// Per-channel read/write valid/ready bus between the GPU data-memory port and data_mem_bank.
// Channel k occupies slice [k*W +: W] of every packed vector.
interface data_mem_bank_if #(
  parameter int ADDR_BITS    = 8,
  parameter int DATA_BITS    = 8,
  parameter int NUM_CHANNELS = 4
) ();
  logic [NUM_CHANNELS-1:0]           data_mem_read_valid;
  logic [NUM_CHANNELS*ADDR_BITS-1:0] data_mem_read_address;
  logic [NUM_CHANNELS-1:0]           data_mem_read_ready;
  logic [NUM_CHANNELS*DATA_BITS-1:0] data_mem_read_data;
  logic [NUM_CHANNELS-1:0]           data_mem_write_valid;
  logic [NUM_CHANNELS*ADDR_BITS-1:0] data_mem_write_address;
  logic [NUM_CHANNELS*DATA_BITS-1:0] data_mem_write_data;
  logic [NUM_CHANNELS-1:0]           data_mem_write_ready;

  modport master (
    output data_mem_read_valid, data_mem_read_address,
           data_mem_write_valid, data_mem_write_address, data_mem_write_data,
    input  data_mem_read_ready, data_mem_read_data, data_mem_write_ready
  );

  modport slave (
    input  data_mem_read_valid, data_mem_read_address,
           data_mem_write_valid, data_mem_write_address, data_mem_write_data,
    output data_mem_read_ready, data_mem_read_data, data_mem_write_ready
  );
endinterface

// File: rtl/data_mem_bank.sv
// Multi-channel data memory with per-channel read/write FSMs, fixed response latency and a host port.
// Define DATA_MEM_ACCESS_COUNTERS_EN to build the per-channel saturating access counters.

// One request FSM; the payload is the address (reads) or {data, address} (writes).
module data_mem_bank_fsm #(
  parameter int LATENCY = 1,
  parameter int PW      = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          valid_i,
  input  logic [PW-1:0] pl_i,
  output logic          commit_o,
  output logic          ready_o,
  output logic [PW-1:0] pl_o
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [PW-1:0] pl_q, pl_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pl_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pl_q    <= pl_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pl_d    = pl_q;
    unique case (state_q)
      IDLE: if (valid_i) begin
        pl_d = pl_i;
        if (LATENCY == 1) state_d = RESP;
        else begin
          cnt_d   = 4'(LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Commit fires on the edge that enters RESP; pl_o is the payload as of that edge.
  // Gated by reset so an abandoned write never reaches the array.
  assign commit_o = !reset && (state_q != RESP) && (state_d == RESP);
  assign ready_o  = (state_q == RESP);
  assign pl_o     = pl_d;
endmodule

module data_mem_bank #(
  parameter int ADDR_BITS    = 8,
  parameter int DATA_BITS    = 8,
  parameter int NUM_CHANNELS = 4,
  parameter int LATENCY      = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  data_mem_bank_if.slave             dmem,
  input  logic                       host_we,
  input  logic [ADDR_BITS-1:0]       host_addr,
  input  logic [DATA_BITS-1:0]       host_wdata,
  output logic [DATA_BITS-1:0]       host_rdata,
  output logic [NUM_CHANNELS*16-1:0] rd_count,
  output logic [NUM_CHANNELS*16-1:0] wr_count
);
  logic [DATA_BITS-1:0] mem_q [2**ADDR_BITS];

  logic [NUM_CHANNELS-1:0]                rd_cmt, wr_cmt, rd_rdy, wr_rdy;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] rd_addr, wr_addr;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] wr_data, rd_data_q;
  logic [DATA_BITS-1:0]                   host_rdata_q;

  for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_ch
    logic [DATA_BITS+ADDR_BITS-1:0] wpl;

    data_mem_bank_fsm #(.LATENCY(LATENCY), .PW(ADDR_BITS)) u_rd (
      .clk      (clk),
      .reset    (reset),
      .valid_i  (dmem.data_mem_read_valid[k]),
      .pl_i     (dmem.data_mem_read_address[k*ADDR_BITS +: ADDR_BITS]),
      .commit_o (rd_cmt[k]),
      .ready_o  (rd_rdy[k]),
      .pl_o     (rd_addr[k])
    );

    data_mem_bank_fsm #(.LATENCY(LATENCY), .PW(ADDR_BITS+DATA_BITS)) u_wr (
      .clk      (clk),
      .reset    (reset),
      .valid_i  (dmem.data_mem_write_valid[k]),
      .pl_i     ({dmem.data_mem_write_data[k*DATA_BITS +: DATA_BITS],
                  dmem.data_mem_write_address[k*ADDR_BITS +: ADDR_BITS]}),
      .commit_o (wr_cmt[k]),
      .ready_o  (wr_rdy[k]),
      .pl_o     (wpl)
    );

    assign wr_addr[k] = wpl[ADDR_BITS-1:0];
    assign wr_data[k] = wpl[ADDR_BITS +: DATA_BITS];
  end

  // Later assignments win: descending channel loop lets ch0 win, host overrides all.
  always_ff @(posedge clk) begin
    for (int k = NUM_CHANNELS - 1; k >= 0; k--)
      if (wr_cmt[k]) mem_q[wr_addr[k]] <= wr_data[k];
    if (host_we) mem_q[host_addr] <= host_wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_q    <= '0;
      host_rdata_q <= '0;
    end else begin
      for (int k = 0; k < NUM_CHANNELS; k++)
        if (rd_cmt[k]) rd_data_q[k] <= mem_q[rd_addr[k]];
      host_rdata_q <= mem_q[host_addr];
    end
  end

  assign dmem.data_mem_read_ready  = rd_rdy;
  assign dmem.data_mem_write_ready = wr_rdy;
  assign dmem.data_mem_read_data   = rd_data_q;
  assign host_rdata                = host_rdata_q;

`ifdef DATA_MEM_ACCESS_COUNTERS_EN
  logic [NUM_CHANNELS-1:0][15:0] rd_cnt_q, wr_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      for (int k = 0; k < NUM_CHANNELS; k++) begin
        if (rd_cmt[k] && rd_cnt_q[k] != 16'hFFFF) rd_cnt_q[k] <= rd_cnt_q[k] + 16'd1;
        if (wr_cmt[k] && wr_cnt_q[k] != 16'hFFFF) wr_cnt_q[k] <= wr_cnt_q[k] + 16'd1;
      end
    end
  end

  assign rd_count = rd_cnt_q;
  assign wr_count = wr_cnt_q;
`else
  assign rd_count = '0;
  assign wr_count = '0;
`endif
endmodule
